gray_serial_tx: RTL and testbench
=================================

// Module: gray_serial_tx
// PURPOSE
//   Source side of the serial Gray-code CDC handshake. Accepts a binary word via valid/ready,
//   converts it to Gray code, shifts it out MSB-first on a_gray_data while a_clk_en is low,
//   then waits for the receiver's b_done acknowledge (synchronised locally) before taking the
//   next word. Sits directly upstream of the serial Gray receiver; widths match its 9-bit frame.
// PARAMETERS
//   DATA_W       9    word / frame length in bits (>=1)
//   SYNC_STAGES  2    flops in the b_done synchroniser (>=2)
//   ACK_TIMEOUT  255  WAIT_ACK cycles before abandoning the frame (>=1)
// PORTS
//   clk          in   1       single clock; all logic on posedge clk
//   reset        in   1       synchronous, active-high reset
//   in_valid     in   1       in_data valid
//   in_ready     out  1       block can accept a word (1 only in IDLE)
//   in_data      in   DATA_W  binary word to transmit
//   a_gray_data  out  1       serial Gray bit, MSB first, registered
//   a_clk_en     out  1       active-low frame enable: 0 while bits are valid, 1 otherwise
//   b_done       in   1       receiver acknowledge, asynchronous to clk
//   busy         out  1       1 in SHIFT or WAIT_ACK
//   timeout_err  out  1       1-cycle pulse when ACK_TIMEOUT expires
// BEHAVIOUR
//   Reset (sync, dominant): state=IDLE, a_clk_en=1, a_gray_data=0, busy=0, timeout_err=0,
//     bit/timeout counters=0, synchroniser flops=0; in_ready=1 from first cycle after reset.
//   Gray: g = bin ^ (bin >> 1), computed at accept, held in DATA_W shift register.
//   IDLE: in_ready=1. in_valid&in_ready at edge T: latch g, bit_cnt=0 -> SHIFT.
//   SHIFT: a_clk_en=0, a_gray_data=g[DATA_W-1-bit_cnt]; first bit valid at T+1, last at
//     T+DATA_W; one bit per cycle, no stalls. After last bit -> WAIT_ACK; a_clk_en=1 at T+DATA_W+1.
//   WAIT_ACK: ack = rising edge of synchronised b_done (sync_q & ~sync_q_d1). Edges seen
//     outside WAIT_ACK ignored. ack -> IDLE. tmo_cnt increments each WAIT_ACK cycle; at
//     tmo_cnt==ACK_TIMEOUT-1 without ack: timeout_err=1 for 1 cycle -> IDLE, word dropped.
//   Simultaneous ack and timeout in same cycle: ack wins, no timeout_err.
//   in_valid while busy: ignored (in_ready=0), no data latched.
//   Back-to-back: in_ready returns 1 the cycle after ack; minimum word period DATA_W+SYNC_STAGES+2.
//   Reset mid-frame: frame abandoned, a_clk_en=1 next cycle, no ack expected, no timeout_err.
//   DATA_W=1: g=bin; single-cycle SHIFT.
//   Counter widths: bit_cnt $clog2(DATA_W+1), tmo_cnt $clog2(ACK_TIMEOUT+1); no wrap reachable.
// STRUCTURE
//   gray_cdc_pkg: state encoding (IDLE=0, SHIFT=1, WAIT_ACK=2), bin2gray function,
//     default DATA_W=9 shared with the receiver.
//   Sub-module cdc_sync_bit (SYNC_STAGES-deep flop chain, reset to 0) for b_done.
//   FSM + shift register + two counters in this module; all outputs registered except in_ready.
// TESTING
//   1. Accept in_data=9'h0B5 -> a_clk_en=0 for 9 cycles, bits 0,1,1,1,0,1,1,1,1 (g=9'h0EF).
//   2. Raise b_done 3 cycles after frame end -> state IDLE, in_ready=1 after SYNC_STAGES+1 cycles.
//   3. b_done held 0 -> timeout_err single pulse after 255 WAIT_ACK cycles, in_ready=1 next cycle.
//   4. reset asserted at 4th SHIFT bit -> next cycle a_clk_en=1, a_gray_data=0, in_ready=1.
//   5. b_done toggled during SHIFT, in_valid held during busy -> no early exit, no extra accept.
//   6. Words 9'h000, 9'h1FF, 9'h155 back-to-back with prompt acks -> Gray 000, 100, 1FF in order.

Source files
------------

// File: rtl/gray_cdc_pkg.sv
// Shared definitions for the serial Gray-code CDC link (transmitter and receiver).
package gray_cdc_pkg;

  // Frame length shared with the serial Gray receiver.
  localparam int GRAY_DATA_W = 9;

  // Widest word the bin2gray helper handles; callers narrow the result.
  localparam int GRAY_MAX_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT    = 2'd1,
    ST_WAIT_ACK = 2'd2
  } tx_state_e;

  // Binary to reflected Gray code. Zero-extended inputs give correct low bits.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level, cleared by reset.
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous level through the flop chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/gray_serial_tx.sv
// Serial Gray-code CDC transmitter: accepts a binary word, shifts its Gray code
// out MSB-first under an active-low frame enable, then waits for the receiver
// acknowledge (or a timeout) before accepting the next word.
//
//   state       | meaning
//   ------------+-------------------------------------------------------------
//   ST_IDLE     | in_ready=1, waiting for in_valid
//   ST_SHIFT    | frame in flight, bit bit_cnt_q on a_gray_data, a_clk_en=0
//   ST_WAIT_ACK | frame sent, waiting for b_done rising edge or timeout
module gray_serial_tx
  import gray_cdc_pkg::*;
#(
  parameter int DATA_W      = GRAY_DATA_W,
  parameter int SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              a_gray_data,
  output logic              a_clk_en,
  input  logic              b_done,
  output logic              busy,
  output logic              timeout_err
);

  localparam int BIT_CNT_W = $clog2(DATA_W + 1);
  localparam int TMO_W     = $clog2(ACK_TIMEOUT + 1);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);
  localparam logic [TMO_W-1:0]     LAST_TMO = TMO_W'(ACK_TIMEOUT - 1);

  tx_state_e             state_q, state_d;
  logic [DATA_W-1:0]     shreg_q, shreg_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic                  a_gray_data_q, a_gray_data_d;
  logic                  a_clk_en_q, a_clk_en_d;
  logic                  busy_q, busy_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  done_sync;
  logic                  done_sync_d1_q;
  logic                  ack;
  logic [DATA_W-1:0]     gray_w;

  cdc_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_done_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (b_done),
    .q_o   (done_sync)
  );

  assign gray_w   = DATA_W'(bin2gray(GRAY_MAX_W'(in_data)));
  assign ack      = done_sync & ~done_sync_d1_q;
  assign in_ready = (state_q == ST_IDLE);

  // Next-state, shift and counter logic. The MSB goes out on the accept edge,
  // so the shift register holds the remaining bits already left-aligned.
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    a_gray_data_d = 1'b0;
    a_clk_en_d    = 1'b1;
    timeout_err_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d       = ST_SHIFT;
          a_gray_data_d = gray_w[DATA_W-1];
          shreg_d       = gray_w << 1;
          bit_cnt_d     = '0;
          a_clk_en_d    = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_q == LAST_BIT) begin
          state_d   = ST_WAIT_ACK;
          tmo_cnt_d = '0;
        end else begin
          bit_cnt_d     = bit_cnt_q + BIT_CNT_W'(1);
          a_gray_data_d = shreg_q[DATA_W-1];
          shreg_d       = shreg_q << 1;
          a_clk_en_d    = 1'b0;
        end
      end
      ST_WAIT_ACK: begin
        // An acknowledge arriving on the last timeout cycle still counts.
        if (ack) begin
          state_d = ST_IDLE;
        end else if (tmo_cnt_q == LAST_TMO) begin
          state_d       = ST_IDLE;
          timeout_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      shreg_q        <= '0;
      bit_cnt_q      <= '0;
      tmo_cnt_q      <= '0;
      a_gray_data_q  <= 1'b0;
      a_clk_en_q     <= 1'b1;
      busy_q         <= 1'b0;
      timeout_err_q  <= 1'b0;
      done_sync_d1_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      shreg_q        <= shreg_d;
      bit_cnt_q      <= bit_cnt_d;
      tmo_cnt_q      <= tmo_cnt_d;
      a_gray_data_q  <= a_gray_data_d;
      a_clk_en_q     <= a_clk_en_d;
      busy_q         <= busy_d;
      timeout_err_q  <= timeout_err_d;
      done_sync_d1_q <= done_sync;
    end
  end

  assign a_gray_data = a_gray_data_q;
  assign a_clk_en    = a_clk_en_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_gray_serial_tx.sv
// Directed bench for gray_serial_tx with hand-computed Gray frames.
module tb_gray_serial_tx;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_data;
  logic       a_gray_data;
  logic       a_clk_en;
  logic       b_done;
  logic       busy;
  logic       timeout_err;

  int checks;
  int errors;

  gray_serial_tx dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .a_gray_data (a_gray_data),
    .a_clk_en    (a_clk_en),
    .b_done      (b_done),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept one word, capture its 9 serial bits and check the enable stays low.
  task automatic send_frame(input logic [8:0] word, input string tag, output logic [8:0] got,
                            output int en_bad, output int rdy_bad);
    in_data  = word;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    got      = '0;
    en_bad   = 0;
    rdy_bad  = 0;
    for (int i = 0; i < 9; i++) begin
      got = {got[7:0], a_gray_data};
      if (a_clk_en !== 1'b0) en_bad++;
      if (in_ready !== 1'b0) rdy_bad++;
      tick();
    end
    chk1({tag, "_clk_en_after"}, a_clk_en, 1'b1);
  endtask

  initial begin
    logic [8:0] got;
    logic [8:0] exp_words [3];
    logic [8:0] exp_gray  [3];
    int en_bad;
    int rdy_bad;
    int tmo_bad;
    int busy_bad;

    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    b_done   = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_clk_en", a_clk_en, 1'b1);
    chk1("rst_gray_data", a_gray_data, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_timeout", timeout_err, 1'b0);

    // 1: 0x0B5 -> Gray 0x0EF, MSB first
    send_frame(9'h0B5, "t1", got, en_bad, rdy_bad);
    chkw("t1_bits", 32'(got), 32'h0EF);
    chkw("t1_en_low_cycles", 32'(en_bad), 32'd0);
    chkw("t1_ready_low", 32'(rdy_bad), 32'd0);
    chk1("t1_busy_wait", busy, 1'b1);
    chk1("t1_gray_idle_low", a_gray_data, 1'b0);

    // 2: acknowledge 3 cycles after frame end; ready after SYNC_STAGES+1 edges
    tick();
    tick();
    b_done = 1'b1;
    tick();
    chk1("t2_ready_e1", in_ready, 1'b0);
    tick();
    chk1("t2_ready_e2", in_ready, 1'b0);
    tick();
    chk1("t2_ready_e3", in_ready, 1'b1);
    chk1("t2_busy", busy, 1'b0);
    b_done = 1'b0;
    tick();
    tick();
    tick();

    // 3: no acknowledge -> timeout after 255 WAIT_ACK cycles
    send_frame(9'h001, "t3", got, en_bad, rdy_bad);
    chkw("t3_bits", 32'(got), 32'h001);
    tmo_bad  = 0;
    busy_bad = 0;
    for (int i = 0; i < 254; i++) begin
      tick();
      if (timeout_err !== 1'b0) tmo_bad++;
      if (busy !== 1'b1) busy_bad++;
    end
    chkw("t3_early_timeout", 32'(tmo_bad), 32'd0);
    chkw("t3_busy_in_wait", 32'(busy_bad), 32'd0);
    tick();
    chk1("t3_timeout_pulse", timeout_err, 1'b1);
    chk1("t3_ready_after", in_ready, 1'b1);
    chk1("t3_busy_after", busy, 1'b0);
    tick();
    chk1("t3_pulse_width", timeout_err, 1'b0);

    // 3b: acknowledge landing on the final timeout cycle wins
    send_frame(9'h0AA, "t3b", got, en_bad, rdy_bad);
    for (int i = 0; i < 252; i++) tick();
    b_done = 1'b1;
    tick();
    tick();
    chk1("t3b_still_busy", busy, 1'b1);
    tick();
    chk1("t3b_ready", in_ready, 1'b1);
    chk1("t3b_no_timeout", timeout_err, 1'b0);
    tick();
    chk1("t3b_no_timeout_late", timeout_err, 1'b0);
    b_done = 1'b0;
    tick();
    tick();
    tick();

    // 4: reset at the 4th SHIFT bit
    in_data  = 9'h0B5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk1("t4_bit3", a_gray_data, 1'b1);
    chk1("t4_en_mid", a_clk_en, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk1("t4_clk_en", a_clk_en, 1'b1);
    chk1("t4_gray_data", a_gray_data, 1'b0);
    chk1("t4_ready", in_ready, 1'b1);
    chk1("t4_busy", busy, 1'b0);

    // 5: b_done pulse during SHIFT and in_valid held while busy
    in_data  = 9'h0B5;
    in_valid = 1'b1;
    tick();
    got     = '0;
    en_bad  = 0;
    rdy_bad = 0;
    for (int i = 0; i < 9; i++) begin
      b_done = (i == 1 || i == 2);
      got = {got[7:0], a_gray_data};
      if (a_clk_en !== 1'b0) en_bad++;
      if (in_ready !== 1'b0) rdy_bad++;
      tick();
    end
    chkw("t5_bits", 32'(got), 32'h0EF);
    chkw("t5_en_low_cycles", 32'(en_bad), 32'd0);
    chkw("t5_ready_low", 32'(rdy_bad), 32'd0);
    tick();
    tick();
    chk1("t5_no_early_exit", busy, 1'b1);
    chk1("t5_clk_en_wait", a_clk_en, 1'b1);
    in_valid = 1'b0;
    b_done   = 1'b1;
    tick();
    tick();
    tick();
    chk1("t5_ready_after_ack", in_ready, 1'b1);
    chk1("t5_no_extra_accept", a_clk_en, 1'b1);
    b_done = 1'b0;
    tick();
    chk1("t5_idle_busy", busy, 1'b0);

    // 6: back-to-back words with prompt acknowledges
    exp_words[0] = 9'h000;
    exp_words[1] = 9'h1FF;
    exp_words[2] = 9'h155;
    exp_gray[0]  = 9'h000;
    exp_gray[1]  = 9'h100;
    exp_gray[2]  = 9'h1FF;
    for (int w = 0; w < 3; w++) begin
      send_frame(exp_words[w], "t6", got, en_bad, rdy_bad);
      chkw($sformatf("t6_word%0d_bits", w), 32'(got), 32'(exp_gray[w]));
      chkw($sformatf("t6_word%0d_en", w), 32'(en_bad), 32'd0);
      b_done = 1'b1;
      tick();
      tick();
      tick();
      chk1($sformatf("t6_word%0d_ready", w), in_ready, 1'b1);
      b_done = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
